// File: rtl/fuzzy_pkg.sv
// Shared fixed-point constants, FSM state type and mu clamp helper for the defuzzifier.
package fuzzy_pkg;

  // Q1.15 firing strength and Q7.0 singleton position widths
  localparam int unsigned Q15_W      = 16;
  localparam int unsigned Q7_W       = 8;
  // mu (<= 1.0) times a Q7.0 position always fits in 24 signed bits
  localparam int unsigned PROD_W     = 24;
  // quotient bits produced by the serial divider (one of them fractional)
  localparam int unsigned DIV_QUOT_W = 10;

  localparam logic [Q15_W-1:0] MU_ONE = 16'h8000;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDiv,
    StDone
  } state_e;

  // Q1.15 codes above 1.0 are not meaningful strengths; pin them to 1.0
  function automatic logic [Q15_W-1:0] clamp_mu(input logic [Q15_W-1:0] mu);
    return (mu > MU_ONE) ? MU_ONE : mu;
  endfunction

endpackage

// File: rtl/udiv_serial.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The start cycle already computes the first bit from the operand inputs, so
// QuotWidth bits are finished after QuotWidth cycles; done_o flags the final one
// and quot_o holds the result from the following cycle until the next start.
// The dividend must satisfy dividend < divisor * 2**QuotWidth, otherwise ovf_o is set.
module udiv_serial #(
  parameter int unsigned DvdWidth  = 29,
  parameter int unsigned DvsWidth  = 20,
  parameter int unsigned QuotWidth = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [DvdWidth-1:0]  dividend_i,
  input  logic [DvsWidth-1:0]  divisor_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [QuotWidth-1:0] quot_o,
  output logic                 ovf_o
);

  localparam int unsigned RemW = DvsWidth + 1;
  localparam int unsigned ExtW = DvdWidth + RemW;
  localparam int unsigned CntW = $clog2(QuotWidth + 1);

  logic [DvsWidth-1:0]  rem_q, rem_d, src_rem, src_dvs, dvs_q, trial;
  logic [QuotWidth-1:0] low_q, low_d, src_low, quot_q, quot_d, src_quot;
  logic [RemW-1:0]      shifted;
  logic [ExtW-1:0]      hi_ext, dvs_ext;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 busy_q, busy_d, ovf_q, ovf_d, fits, step;

  // One restoring step; on start the operands come straight from the inputs
  always_comb begin
    hi_ext   = {{RemW{1'b0}}, dividend_i} >> QuotWidth;
    dvs_ext  = {{(DvdWidth + 1){1'b0}}, divisor_i};
    src_rem  = start_i ? hi_ext[DvsWidth-1:0] : rem_q;
    src_low  = start_i ? dividend_i[QuotWidth-1:0] : low_q;
    src_dvs  = start_i ? divisor_i : dvs_q;
    src_quot = start_i ? '0 : quot_q;
    shifted  = {src_rem, src_low[QuotWidth-1]};
    fits     = shifted >= {1'b0, src_dvs};
    // shifted < 2*divisor, so after a successful subtract the remainder fits DvsWidth
    trial    = shifted[DvsWidth-1:0] - src_dvs;
    rem_d    = fits ? trial : shifted[DvsWidth-1:0];
    quot_d   = {src_quot[QuotWidth-2:0], fits};
    low_d    = {src_low[QuotWidth-2:0], 1'b0};
    ovf_d    = start_i ? (hi_ext >= dvs_ext) : ovf_q;
    step     = start_i || busy_q;
  end

  // Iteration counter and busy/done sequencing
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    done_o = busy_q && (cnt_q == CntW'(QuotWidth - 1));
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CntW'(1);
    end else if (done_o) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      cnt_d  = cnt_q + CntW'(1);
    end
  end

  // Divider datapath and control registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      low_q  <= '0;
      quot_q <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (step) begin
        rem_q  <= rem_d;
        dvs_q  <= src_dvs;
        low_q  <= low_d;
        quot_q <= quot_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign busy_o = busy_q;
  assign quot_o = quot_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/defuzz_wavg.sv
// Weighted-average (singleton) defuzzifier: accumulates sum(mu*pos) and sum(mu)
// over a stream of rule terms, then divides serially and rounds to a Q7.0 output.
module defuzz_wavg
  import fuzzy_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             term_valid,
  output logic             term_ready,
  input  logic [Q15_W-1:0] term_mu,
  input  logic [Q7_W-1:0]  term_pos,
  input  logic             term_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q7_W-1:0]  y,
  output logic             den_zero,
  output logic             trunc
);

  localparam int unsigned CW   = $clog2(MAX_TERMS);
  localparam int unsigned NumW = PROD_W + CW;
  localparam int unsigned DenW = Q15_W + CW;
  localparam int unsigned DvdW = NumW + 1;
  localparam int unsigned CntW = $clog2(MAX_TERMS + 1);

  state_e                   state_q, state_d;
  logic signed [NumW-1:0]   num_q, num_d;
  logic [DenW-1:0]          den_q, den_d;
  logic [CntW-1:0]          cnt_q, cnt_d, idx;
  logic                     trunc_q, trunc_d;

  logic [Q15_W-1:0]         mu_c;
  logic signed [PROD_W-1:0] prod;
  logic                     accept, hit_max, last_eff;

  logic                     num_neg, den_is_zero;
  logic [NumW-1:0]          num_mag;
  logic [DvdW-1:0]          dividend;
  logic                     div_start, div_busy, div_done, div_ovf;
  logic [DIV_QUOT_W-1:0]    quot;
  logic [DIV_QUOT_W:0]      rnd, mag;
  logic [Q7_W-1:0]          y_sat;

  // Term datapath: clamped strength, signed product, truncation detection
  always_comb begin
    mu_c     = clamp_mu(term_mu);
    prod     = PROD_W'($signed({1'b0, mu_c})) * PROD_W'($signed(term_pos));
    accept   = term_valid && term_ready;
    idx      = (state_q == StIdle) ? '0 : cnt_q;
    hit_max  = (idx == CntW'(MAX_TERMS - 1));
    last_eff = term_last || hit_max;
  end

  // FSM next state and accumulator updates
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    den_d      = den_q;
    cnt_d      = cnt_q;
    trunc_d    = trunc_q;
    term_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        term_ready = 1'b1;
        if (accept) begin
          num_d   = NumW'(prod);
          den_d   = DenW'(mu_c);
          cnt_d   = CntW'(1);
          trunc_d = hit_max && !term_last;
          state_d = last_eff ? StDiv : StAcc;
        end
      end
      StAcc: begin
        term_ready = 1'b1;
        if (accept) begin
          num_d   = num_q + NumW'(prod);
          den_d   = den_q + DenW'(mu_c);
          cnt_d   = cnt_q + CntW'(1);
          trunc_d = hit_max && !term_last;
          state_d = last_eff ? StDiv : StAcc;
        end
      end
      StDiv: begin
        if (div_done) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and accumulator registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      num_q   <= '0;
      den_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  // Divider operands: 2*|num| gives the quotient one fractional bit
  always_comb begin
    num_neg   = num_q[NumW-1];
    num_mag   = num_neg ? ($unsigned(~num_q) + NumW'(1)) : $unsigned(num_q);
    dividend  = {num_mag, 1'b0};
    div_start = (state_q == StDiv) && !div_busy;
  end

  udiv_serial #(
    .DvdWidth  (DvdW),
    .DvsWidth  (DenW),
    .QuotWidth (DIV_QUOT_W)
  ) u_div (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (div_start),
    .dividend_i (dividend),
    .divisor_i  (den_q),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quot_o     (quot),
    .ovf_o      (div_ovf)
  );

  // Round half away from zero on the magnitude, re-apply sign, saturate.
  // num/den and the quotient are frozen in DONE, so the result holds under backpressure.
  always_comb begin
    rnd         = {1'b0, quot} + (DIV_QUOT_W + 1)'(1);
    mag         = rnd >> 1;
    den_is_zero = (den_q == '0);
    if (!num_neg) begin
      y_sat = (div_ovf || mag > (DIV_QUOT_W + 1)'(127)) ? 8'h7f : mag[Q7_W-1:0];
    end else begin
      y_sat = (div_ovf || mag > (DIV_QUOT_W + 1)'(128)) ? 8'h80 : (~mag[Q7_W-1:0] + 8'd1);
    end
    out_valid = (state_q == StDone);
    den_zero  = out_valid && den_is_zero;
    y         = (out_valid && !den_is_zero) ? y_sat : '0;
    trunc     = trunc_q;
  end

endmodule

// File: tb/tb_defuzz_wavg.sv
// Directed bench for defuzz_wavg with hand-computed expected results.
module tb_defuzz_wavg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        term_valid = 1'b0;
  logic        term_ready;
  logic [15:0] term_mu = '0;
  logic [7:0]  term_pos = '0;
  logic        term_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  y;
  logic        den_zero;
  logic        trunc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  defuzz_wavg #(
    .MAX_TERMS (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .term_valid (term_valid),
    .term_ready (term_ready),
    .term_mu    (term_mu),
    .term_pos   (term_pos),
    .term_last  (term_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .den_zero   (den_zero),
    .trunc      (trunc)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one term from a negedge; returns at the negedge after it is accepted
  task automatic send(input logic [15:0] mu, input int pos, input logic last);
    int n = 0;
    term_mu    = mu;
    term_pos   = pos[7:0];
    term_last  = last;
    term_valid = 1'b1;
    while (!term_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!term_ready) check("accept_timeout", 0, 1);
    @(negedge clk);
    term_valid = 1'b0;
    term_last  = 1'b0;
  endtask

  // Called at the first negedge after the last term was accepted
  task automatic expect_result(input string tag, input int ey, input int edz, input int etr,
                               input int hold);
    int lat = 1;
    check({tag, "_ready_drop"}, term_ready, 0);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 11);
    check({tag, "_y"}, $signed(y), ey);
    check({tag, "_den_zero"}, den_zero, edz);
    check({tag, "_trunc"}, trunc, etr);
    for (int k = 0; k < hold; k++) begin
      term_valid = 1'b1;
      term_mu    = 16'h8000;
      term_pos   = 8'd99;
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_y"}, $signed(y), ey);
      check({tag, "_hold_trunc"}, trunc, etr);
      check({tag, "_hold_ready"}, term_ready, 0);
    end
    term_valid = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_clr"}, out_valid, 0);
    check({tag, "_ready_back"}, term_ready, 1);
  endtask

  initial begin
    int seen;

    repeat (2) @(negedge clk);
    check("rst_term_ready", term_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", $signed(y), 0);
    check("rst_den_zero", den_zero, 0);
    check("rst_trunc", trunc, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(16'h8000, 40, 1'b1);
    expect_result("single", 40, 0, 0, 0);

    send(16'h8000, 100, 1'b0);
    send(16'h4000, 10, 1'b1);
    expect_result("wavg70", 70, 0, 0, 0);

    send(16'h4000, -64, 1'b0);
    send(16'h4000, 64, 1'b1);
    expect_result("cancel", 0, 0, 0, 0);

    send(16'h8000, 1, 1'b0);
    send(16'h8000, 2, 1'b1);
    expect_result("round_pos", 2, 0, 0, 0);

    send(16'h8000, -1, 1'b0);
    send(16'h8000, -2, 1'b1);
    expect_result("round_neg", -2, 0, 0, 0);

    send(16'h0000, 30, 1'b0);
    send(16'h0000, -50, 1'b0);
    send(16'h0000, 90, 1'b1);
    expect_result("den0", 0, 1, 0, 0);

    send(16'hffff, 5, 1'b1);
    expect_result("clamp", 5, 0, 0, 0);

    send(16'h8000, 127, 1'b1);
    expect_result("max_pos", 127, 0, 0, 0);

    send(16'h8000, -128, 1'b1);
    expect_result("max_neg", -128, 0, 0, 0);

    // 16 terms, none marked last: 8 at +20 and 8 at +30, equal weight -> 25
    for (int i = 0; i < 16; i++) begin
      send(16'h1000, (i % 2 == 0) ? 20 : 30, 1'b0);
    end
    expect_result("trunc16", 25, 0, 1, 5);

    // Reset in the 4th DIV cycle: nothing may come out
    send(16'h8000, 50, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_term_ready", term_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_y", $signed(y), 0);
    check("midrst_den_zero", den_zero, 0);
    check("midrst_trunc", trunc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("midrst_no_result", seen, 0);

    send(16'h8000, -7, 1'b1);
    expect_result("after_rst", -7, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/defuzz_wavg.md
DEFUZZ_WAVG -- requirements
Module: defuzz_wavg

Interface
REQ-001 SHALL have parameter MAX_TERMS, default 16: maximum rule terms per transaction.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port term_valid, input, 1 bit: a rule term is presented.
REQ-005 SHALL have port term_ready, output, 1 bit: the block accepts a term this cycle.
REQ-006 SHALL have port term_mu, input, 16 bits, unsigned Q1.15: rule firing strength.
REQ-007 SHALL have port term_pos, input, 8 bits, signed Q7.0: output singleton position.
REQ-008 SHALL have port term_last, input, 1 bit: final term of the transaction.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port y, output, 8 bits, signed Q7.0: crisp output.
REQ-012 SHALL have port den_zero, output, 1 bit: sum of mu was zero.
REQ-013 SHALL have port trunc, output, 1 bit: transaction was cut at MAX_TERMS.

Function
REQ-014 SHALL implement an FSM with states IDLE, ACC, DIV and DONE.
REQ-015 SHALL drive term_ready=1 only in IDLE and ACC; a term is accepted when term_valid and term_ready are both 1.
REQ-016 SHALL, on a term accepted in IDLE, load num=mu*pos and den=mu, clear trunc and the term count, then enter ACC (or DIV if last).
REQ-017 SHALL, on a term accepted in ACC, add mu*pos to num and mu to den.
REQ-018 SHALL clamp term_mu values above 0x8000 to 0x8000 before use.
REQ-019 SHALL compute mu*pos as a 24-bit signed product and size num at 24+clog2(MAX_TERMS) bits and den at 16+clog2(MAX_TERMS) bits, so neither can overflow.
REQ-020 SHALL treat the MAX_TERMS-th accepted term as last even if term_last=0, and set trunc=1 in that case.
REQ-021 SHALL enter DIV the cycle after the last term is accepted, and SHALL drop term_ready in that same cycle.
REQ-022 SHALL, in DIV, perform restoring division |num|/den at one bit per cycle for 10 cycles, producing a quotient with 1 fractional bit.
REQ-023 SHALL round the quotient half away from zero, apply the sign of num, and saturate y to [-128,127].
REQ-024 SHALL, when den==0, still spend 10 cycles in DIV, then output y=0 and den_zero=1.
REQ-025 SHALL assert out_valid exactly 11 cycles after the cycle in which the last term is accepted (state DONE).
REQ-026 SHALL hold y, den_zero and trunc stable while out_valid=1 and out_ready=0.
REQ-027 SHALL return to IDLE on the cycle out_valid and out_ready are both 1, deasserting out_valid.
REQ-028 SHALL drive term_ready=0 in DONE, so no new term is accepted in the cycle the result is taken.

Reset
REQ-029 SHALL, while rst_n=0, force state=IDLE, num=0, den=0, count=0, y=0, den_zero=0, trunc=0 and out_valid=0, with term_ready=1.
REQ-030 SHALL abandon any transaction in progress when reset occurs mid-ACC or mid-DIV; no partial result is ever emitted.

Structure
REQ-031 SHALL take the Q1.15 and Q7.0 width constants, the MU_ONE=0x8000 constant and the FSM state enum from the shared package fuzzy_pkg.
REQ-032 SHALL implement the 10-cycle restoring divider as sub-module udiv_serial, with a start/done handshake and parameterised dividend and divisor widths.

Verification
REQ-033 SHALL cover: one term (mu=0x8000, pos=+40, last) -> y=40, den_zero=0, out_valid exactly 11 cycles after acceptance.
REQ-034 SHALL cover: (0x8000,+100) then (0x4000,+10,last) -> y=70; and (0x4000,-64) then (0x4000,+64,last) -> y=0.
REQ-035 SHALL cover rounding: (0x8000,+1) then (0x8000,+2,last) -> y=+2; (0x8000,-1) then (0x8000,-2,last) -> y=-2.
REQ-036 SHALL cover: three terms with mu=0 -> y=0, den_zero=1; and term_mu=0xFFFF with pos=+5 -> y=5 (mu clamped).
REQ-037 SHALL cover: 16 terms with no term_last -> trunc=1, term_ready=0 from the cycle after the 16th term; then out_ready low for 5 cycles -> y stable and term_ready=0 throughout.
REQ-038 SHALL cover: rst_n pulsed low in DIV cycle 4 -> all outputs at reset values, no out_valid; the next transaction (0x8000,-7,last) -> y=-7.
